// File: rtl/alu_share_arb.sv
// alu_share_arb: two-port arbiter time-sharing one external ALU, with a one-entry tagged response register
module alu_share_arb #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_ctrl,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err,
  input  logic        flush
);
  logic        r_full, r_last, r_id, r_zero, r_err;
  logic [31:0] r_result;
  logic        w_can_issue, w_grant1, w_acc;
  always_comb begin
    w_can_issue   = ~r_full | rsp_ready;
    // port 1 wins when alone, or on a round-robin tie after port 0 was last served
    w_grant1      = req1_valid & (~req0_valid | (~FIXED_PRIO & ~r_last));
    req0_ready    = ~rst & ~flush & w_can_issue & req0_valid & ~w_grant1;
    req1_ready    = ~rst & ~flush & w_can_issue & w_grant1;
    w_acc         = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    alu_operand_a = w_grant1 ? req1_a : req0_a;
    alu_operand_b = w_grant1 ? req1_b : req0_b;
    alu_ctrl      = w_grant1 ? req1_ctrl : req0_ctrl;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full   <= 1'b0;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_full <= w_acc | (r_full & ~rsp_ready & ~flush);
      if (w_acc) begin
        r_last   <= w_grant1;
        r_id     <= w_grant1;
        r_result <= alu_result;
        r_zero   <= alu_zero;
        r_err    <= alu_ctrl >= 4'd10;
      end
    end
  end
  assign rsp_valid  = r_full;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_err    = r_err;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: round-robin and fixed-priority instances driven together, checked against a transaction-level model
module tb_alu_share_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, flush, rsp_ready, v0, v1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  c0, c1;
  logic [1:0]  rdy0, rdy1, rv, rid, rz, re, az;
  logic [31:0] oa [2];
  logic [31:0] ob [2];
  logic [31:0] res [2];
  logic [31:0] rres [2];
  logic [3:0]  oc [2];
  int n_cmp = 0;
  int n_mis = 0;
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return {31'b0, $signed(a) < $signed(b)};
      4'd6: return {31'b0, a < b};
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign res[g] = alu_f(oa[g], ob[g], oc[g]);
    assign az[g]  = res[g] == 32'd0;
    alu_share_arb #(.FIXED_PRIO(g == 1)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_ready(rdy0[g]), .req0_a(a0), .req0_b(b0), .req0_ctrl(c0),
      .req1_valid(v1), .req1_ready(rdy1[g]), .req1_a(a1), .req1_b(b1), .req1_ctrl(c1),
      .alu_operand_a(oa[g]), .alu_operand_b(ob[g]), .alu_ctrl(oc[g]),
      .alu_result(res[g]), .alu_zero(az[g]),
      .rsp_valid(rv[g]), .rsp_ready(rsp_ready), .rsp_id(rid[g]), .rsp_result(rres[g]),
      .rsp_zero(rz[g]), .rsp_err(re[g]), .flush(flush)
    );
  end
  // Model: what each instance should hold, in terms of served requests
  bit          m_full [2], m_last [2], m_id [2], m_zero [2], m_err [2], m_clean [2];
  logic [31:0] m_res [2];
  task automatic chk(input string tag, input int p, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, p, obs, exp);
    end
  endtask
  function automatic int m_grant(input int p);
    if (v0 && v1) return (p == 1 || m_last[p]) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction
  function automatic bit m_ready(input int p, input int n);
    return !rst && !flush && (!m_full[p] || rsp_ready) && m_grant(p) == n;
  endfunction
  function automatic void m_reset(input int p);
    m_full[p] = 0; m_last[p] = 1; m_id[p] = 0; m_res[p] = 0;
    m_zero[p] = 0; m_err[p] = 0; m_clean[p] = 1;
  endfunction
  task automatic tick();
    int gr [2];
    bit acc [2];
    logic [31:0] r;
    #1;
    for (int p = 0; p < 2; p++) begin
      gr[p] = m_grant(p);
      acc[p] = gr[p] >= 0 && m_ready(p, gr[p]);
      chk("ready0", p, {31'b0, rdy0[p]}, {31'b0, m_ready(p, 0)});
      chk("ready1", p, {31'b0, rdy1[p]}, {31'b0, m_ready(p, 1)});
      if (gr[p] >= 0) begin
        chk("alu_a", p, oa[p], gr[p] == 1 ? a1 : a0);
        chk("alu_ctrl", p, {28'b0, oc[p]}, {28'b0, gr[p] == 1 ? c1 : c0});
      end
    end
    @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      if (rst) m_reset(p);
      else if (acc[p]) begin
        r = gr[p] == 1 ? alu_f(a1, b1, c1) : alu_f(a0, b0, c0);
        m_full[p] = 1; m_last[p] = gr[p] == 1; m_id[p] = gr[p] == 1; m_res[p] = r;
        m_zero[p] = r == 0; m_err[p] = (gr[p] == 1 ? c1 : c0) >= 4'd10; m_clean[p] = 0;
      end else if (flush || rsp_ready) m_full[p] = 0;
    end
    #1;
    for (int p = 0; p < 2; p++) begin
      chk("rsp_valid", p, {31'b0, rv[p]}, {31'b0, m_full[p]});
      if (m_full[p] || m_clean[p]) begin
        chk("rsp_id", p, {31'b0, rid[p]}, {31'b0, m_id[p]});
        chk("rsp_result", p, rres[p], m_res[p]);
        chk("rsp_zero", p, {31'b0, rz[p]}, {31'b0, m_zero[p]});
        chk("rsp_err", p, {31'b0, re[p]}, {31'b0, m_err[p]});
      end
    end
    @(negedge clk);
  endtask
  initial begin
    rst = 1; flush = 0; rsp_ready = 1; v0 = 0; v1 = 0;
    a0 = 0; b0 = 0; c0 = 0; a1 = 0; b1 = 0; c1 = 0;
    for (int p = 0; p < 2; p++) m_reset(p);
    @(negedge clk);
    tick(); tick();
    rst = 0;
    chk("rst_valid", 0, {31'b0, rv[0]}, 32'd0);
    // port 0 alone: 5 + 3
    v0 = 1; a0 = 5; b0 = 3; c0 = 4'd0;
    tick();
    v0 = 0;
    for (int p = 0; p < 2; p++) begin
      chk("add_res", p, rres[p], 32'd8);
      chk("add_id", p, {31'b0, rid[p]}, 32'd0);
    end
    // tie after reset: round robin alternates starting at 0, fixed stays at 0
    rst = 1; tick(); rst = 0;
    v0 = 1; a0 = 7; b0 = 7; c0 = 4'd1;
    v1 = 1; a1 = 32'hF0; b1 = 32'h0F; c1 = 4'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_id", 0, {31'b0, rid[0]}, i & 1);
      chk("rr_res", 0, rres[0], (i & 1) ? 32'hFF : 32'd0);
      chk("fp_id", 1, {31'b0, rid[1]}, 32'd0);
      chk("fp_zero", 1, {31'b0, rz[1]}, 32'd1);
    end
    // backpressure with SRA result held
    v1 = 0; a0 = 32'h8000_0000; b0 = 4; c0 = 4'd9;
    tick();
    v0 = 0; v1 = 1; a1 = 32'd9; b1 = 32'd1; c1 = 4'd0; rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        chk("bp_hold", p, rres[p], 32'hF800_0000);
        chk("bp_rdy1", p, {31'b0, rdy1[p]}, 32'd0);
      end
    end
    rsp_ready = 1;
    #1 chk("bp_release", 0, {31'b0, rdy1[0]}, 32'd1);
    tick();
    chk("bp_id", 1, {31'b0, rid[1]}, 32'd1);
    chk("bp_res", 1, rres[1], 32'd10);
    // undefined op code on port 1
    c1 = 4'b1100;
    tick();
    v1 = 0;
    for (int p = 0; p < 2; p++) begin
      chk("err_flag", p, {31'b0, re[p]}, 32'd1);
      chk("err_res", p, rres[p], 32'd0);
      chk("err_zero", p, {31'b0, rz[p]}, 32'd1);
    end
    // flush a held response while a request waits
    rsp_ready = 0; tick();
    flush = 1; v0 = 1; c0 = 4'd0; tick();
    flush = 0; v0 = 0;
    chk("flush_valid", 0, {31'b0, rv[0]}, 32'd0);
    tick();
    // reset mid-stream, then port 0 wins the tie
    rsp_ready = 1; v0 = 1; v1 = 1; tick(); tick();
    rst = 1; tick(); rst = 0;
    chk("mid_rst_res", 0, rres[0], 32'd0);
    tick();
    chk("post_rst_id", 0, {31'b0, rid[0]}, 32'd0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 63) == 0;
      flush = $urandom_range(0, 15) == 0;
      rsp_ready = $urandom_range(0, 3) != 0;
      if (!v0 || rdy0[0] || rdy0[1] || $urandom_range(0, 3) == 0) begin
        v0 = $urandom_range(0, 2) != 0; a0 = $urandom;
        b0 = $urandom_range(0, 1) ? $urandom : a0; c0 = 4'($urandom_range(0, 15));
      end
      if (!v1 || rdy1[0] || rdy1[1] || $urandom_range(0, 3) == 0) begin
        v1 = $urandom_range(0, 2) != 0; a1 = $urandom;
        b1 = $urandom_range(0, 31); c1 = 4'($urandom_range(0, 15));
      end
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
